// File: rtl/bram_stack_if.sv
// Command/status bundle between the calculator control FSM and bram_stack.
// Optional macro BRAM_STACK_SECOND_EN adds the 'second' status signal.
//
// Handshake: out_vld is the single valid/ready indication. While out_vld=1,
// top/size/error are valid and exactly one push/pop/replace pulse sampled on
// the next rising edge is accepted. While out_vld=0, command inputs are
// ignored and nothing changes.
interface bram_stack_if #(
  parameter int WIDTH     = 32,
  parameter int SIZE_BITS = 10
);
  logic                 push;
  logic                 pop;
  logic                 replace;
  logic [WIDTH-1:0]     in_num;
  logic [WIDTH-1:0]     top;
  logic [SIZE_BITS-1:0] size;
  logic                 error;
  logic                 out_vld;
`ifdef BRAM_STACK_SECOND_EN
  logic [WIDTH-1:0]     second;

  modport master (output push, pop, replace, in_num,
                  input  top, size, error, out_vld, second);
  modport slave  (input  push, pop, replace, in_num,
                  output top, size, error, out_vld, second);
`else
  modport master (output push, pop, replace, in_num,
                  input  top, size, error, out_vld);
  modport slave  (input  push, pop, replace, in_num,
                  output top, size, error, out_vld);
`endif
endinterface

// File: rtl/bram_stack.sv
// LIFO operand store: top element (and optionally the one below it) held in
// registers, deeper elements in a single-port block RAM with a 1-cycle
// synchronous read. A pop costs two dead cycles while the new top is fetched.
// Optional macro BRAM_STACK_SECOND_EN: keeps the second element in a register
// and exposes it on the 'second' output.
module bram_stack #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 512,
  parameter int SIZE_BITS = 10
) (
  input  logic         clk,
  input  logic         reset,
  bram_stack_if.slave  bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2
  } state_t;

  // Number of stack elements held in registers rather than RAM.
`ifdef BRAM_STACK_SECOND_EN
  localparam int REG_ELEMS = 2;
`else
  localparam int REG_ELEMS = 1;
`endif
  localparam int RAM_WORDS = (DEPTH > REG_ELEMS) ? (DEPTH - REG_ELEMS) : 1;
  localparam int AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [SIZE_BITS-1:0] DEPTH_S = SIZE_BITS'(DEPTH);
  localparam logic [SIZE_BITS-1:0] REG_S   = SIZE_BITS'(REG_ELEMS);
  localparam logic [SIZE_BITS-1:0] ONE_S   = SIZE_BITS'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     top_q;
  logic [SIZE_BITS-1:0] size_q;
  logic                 error_q;
  logic [AW-1:0]        rd_addr_q;
`ifdef BRAM_STACK_SECOND_EN
  logic [WIDTH-1:0]     second_q;
`endif

  logic [WIDTH-1:0]     mem [RAM_WORDS];
  logic [WIDTH-1:0]     rd_data;
  logic                 ram_we;
  logic [AW-1:0]        ram_addr;
  logic [WIDTH-1:0]     ram_wdata;

  logic       accept;
  logic [1:0] cmd_cnt;
  logic       multi_cmd;
  logic       push_ok, push_bad;
  logic       pop_ok, pop_bad;
  logic       rep_ok, rep_bad;
  logic       cmd_err;

  // Command decode: only one command may be applied per accepted edge.
  always_comb begin
    accept    = (state_q == IDLE);
    cmd_cnt   = {1'b0, bus.push} + {1'b0, bus.pop} + {1'b0, bus.replace};
    multi_cmd = accept && (cmd_cnt > 2'd1);
    push_ok   = accept && (cmd_cnt == 2'd1) && bus.push    && (size_q != DEPTH_S);
    push_bad  = accept && (cmd_cnt == 2'd1) && bus.push    && (size_q == DEPTH_S);
    pop_ok    = accept && (cmd_cnt == 2'd1) && bus.pop     && (size_q != '0);
    pop_bad   = accept && (cmd_cnt == 2'd1) && bus.pop     && (size_q == '0);
    rep_ok    = accept && (cmd_cnt == 2'd1) && bus.replace && (size_q != '0);
    rep_bad   = accept && (cmd_cnt == 2'd1) && bus.replace && (size_q == '0);
    cmd_err   = multi_cmd || push_bad || pop_bad || rep_bad;
  end

  // Next-state logic for the pop fetch sequence.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:     state_d = pop_ok ? RD_ISSUE : IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State register. Reset parks in RD_WAIT so out_vld stays low for exactly
  // one cycle after reset, and any fetch in flight is discarded because the
  // RD_WAIT exit sees size=0.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RD_WAIT;
    else       state_q <= state_d;
  end

  // RAM port control: pushes spill the lowest register element into RAM;
  // RD_ISSUE presents the latched pop address. The two never coincide.
  always_comb begin
    ram_we    = push_ok && (size_q >= REG_S);
    ram_wdata = top_q;
`ifdef BRAM_STACK_SECOND_EN
    ram_wdata = second_q;
`endif
    ram_addr  = (state_q == RD_ISSUE) ? rd_addr_q : AW'(size_q - REG_S);
  end

  // Single-port block RAM, read-first, synchronous read.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  // Stack registers: size, top, optional second, error flag, pop address.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q    <= '0;
      top_q     <= '0;
      error_q   <= 1'b0;
      rd_addr_q <= '0;
`ifdef BRAM_STACK_SECOND_EN
      second_q  <= '0;
`endif
    end else begin
      if (cmd_err) error_q <= 1'b1;
      if (push_ok) begin
        top_q   <= bus.in_num;
        size_q  <= size_q + ONE_S;
        error_q <= 1'b0;
`ifdef BRAM_STACK_SECOND_EN
        // top is 0 when empty, so second stays 0 after the first push
        second_q <= top_q;
`endif
      end
      if (rep_ok) begin
        top_q   <= bus.in_num;
        error_q <= 1'b0;
      end
      if (pop_ok) begin
        size_q    <= size_q - ONE_S;
        error_q   <= 1'b0;
        // address of the element that becomes the lowest register element;
        // wraps when the new size is too small, and that read is discarded
        rd_addr_q <= AW'(size_q - ONE_S - REG_S);
`ifdef BRAM_STACK_SECOND_EN
        top_q     <= second_q;
`endif
      end
      if (state_q == RD_WAIT) begin
`ifdef BRAM_STACK_SECOND_EN
        second_q <= (size_q < REG_S) ? '0 : rd_data;
`else
        top_q    <= (size_q == '0) ? '0 : rd_data;
`endif
      end
    end
  end

  assign bus.top     = top_q;
  assign bus.size    = size_q;
  assign bus.error   = error_q;
  assign bus.out_vld = (state_q == IDLE);
`ifdef BRAM_STACK_SECOND_EN
  assign bus.second  = second_q;
`endif
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bram_stack.sv
// Bench for bram_stack: two instances (DEPTH=512 and DEPTH=4) driven by the
// same command stream and compared every cycle against an array-based LIFO
// reference model.
module tb_bram_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic        push, pop, replace;
  logic [31:0] in_num;
  logic [1:0]  dbg0, dbg1;

  int vectors     = 0;
  int miscompares = 0;

  bram_stack_if #(.WIDTH(32), .SIZE_BITS(10)) bus0 ();
  bram_stack_if #(.WIDTH(32), .SIZE_BITS(10)) bus1 ();

  assign bus0.push = push;  assign bus0.pop = pop;
  assign bus0.replace = replace;  assign bus0.in_num = in_num;
  assign bus1.push = push;  assign bus1.pop = pop;
  assign bus1.replace = replace;  assign bus1.in_num = in_num;

  bram_stack #(.WIDTH(32), .DEPTH(512), .SIZE_BITS(10)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state(dbg0));
  bram_stack #(.WIDTH(32), .DEPTH(4), .SIZE_BITS(10)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state(dbg1));

  // clock
  always #5 clk = ~clk;

  // reference model: stack contents as a plain array per instance
  logic [31:0] mstk [2][512];
  int          msz   [2];
  int          mwait [2];
  logic        merr  [2];
  bit          mpopd [2];
  int          mdepth [2] = '{512, 4};

  task automatic model_edge(input int k, input logic rst, input logic p,
                            input logic po, input logic r, input logic [31:0] d);
    int n;
    n = int'(p) + int'(po) + int'(r);
    if (rst) begin
      msz[k] = 0; merr[k] = 1'b0; mwait[k] = 1; mpopd[k] = 1'b0;
    end else if (mwait[k] > 0) begin
      mwait[k]--;
      if (mwait[k] == 0) mpopd[k] = 1'b0;
    end else if (n > 1) begin
      merr[k] = 1'b1;
    end else if (p) begin
      if (msz[k] == mdepth[k]) merr[k] = 1'b1;
      else begin mstk[k][msz[k]] = d; msz[k]++; merr[k] = 1'b0; end
    end else if (po) begin
      if (msz[k] == 0) merr[k] = 1'b1;
      else begin msz[k]--; merr[k] = 1'b0; mwait[k] = 2; mpopd[k] = 1'b1; end
    end else if (r) begin
      if (msz[k] == 0) merr[k] = 1'b1;
      else begin mstk[k][msz[k]-1] = d; merr[k] = 1'b0; end
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] etop, esec;
    for (int k = 0; k < 2; k++) begin
      etop = (msz[k] > 0) ? mstk[k][msz[k]-1] : 32'h0;
      esec = (msz[k] > 1) ? mstk[k][msz[k]-2] : 32'h0;
      if (k == 0) begin
        chk("out_vld", k, {31'b0, bus0.out_vld}, {31'b0, mwait[k] == 0});
        chk("size", k, {22'b0, bus0.size}, 32'(msz[k]));
        chk("error", k, {31'b0, bus0.error}, {31'b0, merr[k]});
        if (!mpopd[k]) chk("top", k, bus0.top, etop);
`ifdef BRAM_STACK_SECOND_EN
        if (!mpopd[k]) chk("second", k, bus0.second, esec);
`endif
      end else begin
        chk("out_vld", k, {31'b0, bus1.out_vld}, {31'b0, mwait[k] == 0});
        chk("size", k, {22'b0, bus1.size}, 32'(msz[k]));
        chk("error", k, {31'b0, bus1.error}, {31'b0, merr[k]});
        if (!mpopd[k]) chk("top", k, bus1.top, etop);
`ifdef BRAM_STACK_SECOND_EN
        if (!mpopd[k]) chk("second", k, bus1.second, esec);
`endif
      end
    end
  endtask

  // driver: apply one cycle of inputs, advance the model at the edge,
  // check outputs on the following falling edge
  task automatic step(input logic rst, input logic p, input logic po,
                      input logic r, input logic [31:0] d);
    reset = rst; push = p; pop = po; replace = r; in_num = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, rst, p, po, r, d);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_push(input logic [31:0] d); step(0, 1, 0, 0, d); endtask
  task automatic do_rep(input logic [31:0] d);  step(0, 0, 0, 1, d); endtask
  task automatic do_idle();                      step(0, 0, 0, 0, 32'h0); endtask
  task automatic do_pop();
    step(0, 0, 1, 0, 32'h0);
    do_idle();
    do_idle();
  endtask

  initial begin
    int sel;
    reset = 1'b1; push = 1'b0; pop = 1'b0; replace = 1'b0; in_num = '0;
    for (int k = 0; k < 2; k++) begin
      msz[k] = 0; mwait[k] = 1; merr[k] = 1'b0; mpopd[k] = 1'b0;
    end

    // 1: reset, release, first push
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);
    do_idle();
    do_push(32'h0000_0012);

    // 2: push 1,2,3 then pop three times
    do_push(32'h1); do_push(32'h2); do_push(32'h3);
    do_pop(); do_pop(); do_pop();
    do_pop();

    // 3: pop on empty, then push 5
    step(0, 0, 1, 0, 32'h0);
    do_idle();
    do_push(32'h5);
    do_pop();

    // 4: fill past DEPTH=4 on the small instance, then drain
    do_push(32'hA); do_push(32'hB); do_push(32'hC); do_push(32'hD);
    do_push(32'hE);
    for (int i = 0; i < 5; i++) do_pop();

    // 5: replace, double command, push during pop dead cycles
    do_push(32'h7); do_push(32'h9);
    do_rep(32'h0000_ABCD);
    step(0, 1, 1, 0, 32'h1234);
    step(0, 0, 1, 0, 32'h0);
    step(0, 1, 0, 0, 32'h55);
    step(0, 1, 0, 0, 32'h66);
    do_idle();
    do_pop();

    // 6: reset during RD_WAIT of a pop
    do_push(32'h21); do_push(32'h22); do_push(32'h23);
    step(0, 0, 1, 0, 32'h0);
    do_idle();
    step(1, 0, 0, 0, 32'h0);
    do_idle();
    do_idle();

    // fill the large instance to its limit and drain it
    for (int i = 0; i < 514; i++) do_push($urandom);
    for (int i = 0; i < 513; i++) do_pop();

    // randomized command mix
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 99);
      if      (sel < 40) step(0, 1, 0, 0, $urandom);
      else if (sel < 65) step(0, 0, 1, 0, $urandom);
      else if (sel < 78) step(0, 0, 0, 1, $urandom);
      else if (sel < 85) step(0, 1'($urandom), 1, 1'($urandom), $urandom);
      else if (sel < 87) step(1, 1'($urandom), 1'($urandom), 0, $urandom);
      else               step(0, 0, 0, 0, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_stack.md
Name: bram_stack

Overview:
- LIFO operand store for the calculator datapath.
- Sits directly downstream of the calculator control FSM, which issues single-cycle push/pop/replace/reset pulses.
- Returns the top of stack, element count, error flag and a ready/valid indication that the controller waits on before issuing the next command.
- Top element lives in a register; deeper elements live in a single-port, 1-cycle-read block RAM.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 512, maximum number of elements. Legal range 2..2^SIZE_BITS-1. RAM holds DEPTH-1 words.
- SIZE_BITS, 10, width of the size output.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; empties stack
- push  in  1  single-cycle command: push in_num
- pop  in  1  single-cycle command: discard top
- replace  in  1  single-cycle command: overwrite top with in_num
- in_num  in  WIDTH  operand for push/replace
- top  out  WIDTH  current top element; 0 when empty
- size  out  SIZE_BITS  number of elements held
- error  out  1  last command was illegal
- out_vld  out  1  top/size valid and a command will be accepted

Behaviour:
- Reset (sampled high at an edge):
  - Next cycle: size=0, top=0, error=0, out_vld=0.
  - out_vld=1 on the first cycle after reset is sampled low.
  - Reset overrides any command in flight, including a pending pop read; the read result is discarded.
  - RAM contents are not cleared.
- Command acceptance:
  - A command is sampled only on an edge where out_vld=1. Commands seen while out_vld=0 are ignored silently: no state change, error unchanged.
  - More than one of push/pop/replace high on an accepted edge → error=1, no other change.
- States: IDLE (out_vld=1), RD_ISSUE, RD_WAIT. Transitions: IDLE→RD_ISSUE on accepted pop, RD_ISSUE→RD_WAIT, RD_WAIT→IDLE.
- push accepted at edge T:
  - If size==DEPTH: error=1, nothing else changes.
  - Else, visible in cycle T+1: if size>0, old top is written to RAM[size-1]; top=in_num; size+1; error=0.
  - out_vld stays 1.
- replace accepted at T:
  - If size==0: error=1, nothing else changes.
  - Else, visible in T+1: top=in_num; size unchanged; error=0; out_vld stays 1.
- pop accepted at T:
  - If size==0: error=1, out_vld stays 1, nothing else changes.
  - Else in T+1: out_vld=0, size-1, error=0, RAM read address driven to new_size-1. Address is driven even when new_size==0; that result is discarded.
  - T+2: out_vld stays 0, RAM data returns.
  - T+3: out_vld=1. top = RAM data, or 0 if new size==0.
  - Latency is a fixed 2 dead cycles regardless of depth.
- error:
  - Sticky across ignored commands.
  - Cleared by reset or by the next legal accepted command.
- size arithmetic:
  - Unsigned, never wraps. Overflow and underflow are blocked by the error rules above.
- RAM:
  - One port; a write and a read never occur in the same cycle, by construction.
  - Inference-friendly synchronous read.

Optional Feature:
- Macro: BRAM_STACK_SECOND_EN.
- When defined:
  - Adds output second (WIDTH): element directly below top, 0 when size<2.
  - second is held in a register. RAM then holds elements below second, in DEPTH-2 words.
  - push: RAM[size-2] ← second if size≥2; second ← old top.
  - pop: top ← second; second ← RAM[new_size-2] with the same 2-cycle latency, or 0 if new size<2.
  - replace leaves second unchanged.
  - out_vld timing is identical to the base block.
- When undefined: port absent, behaviour exactly as above.

Test Plan:
1. Reset 3 cycles, release, then push in_num=0x00000012.
   - Required: out_vld=1 on the first cycle after release.
   - Required: next cycle top=0x12, size=1, error=0, out_vld never drops.
2. Push 1, 2, 3, then pop.
   - Required: out_vld=0 for exactly 2 cycles, size=2 from the first of them, then top=2.
   - Pop twice more. Required: top=1 then top=0, size=0.
3. Pop on empty.
   - Required: error=1, size=0, top=0, out_vld stays 1.
   - Then push 5. Required: error=0, top=5, size=1.
4. DEPTH=4 override: push 0xA, 0xB, 0xC, 0xD, then push 0xE.
   - Required: error=1, size=4, top=0xD.
   - Pop four times. Required: tops 0xC, 0xB, 0xA, 0, no errors.
5. Size 2 (pushed 7, 9): replace 0xABCD.
   - Required: top=0xABCD, size=2.
   - Push and pop high on the same edge. Required: error=1, top/size unchanged.
   - Pop, then assert push during the dead cycles. Required: push ignored, top=7, size=1.
6. Size 3: pop, then assert reset in the RD_WAIT cycle.
   - Required: next cycle size=0, top=0, error=0, out_vld=0.
   - Required: out_vld=1 one cycle after reset release; no stale top value appears.
